// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch-type encodings, default widths and the PC step.
package cpu_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned PC_STEP      = 4;

    localparam logic [1:0] BR_EQ = 2'b00;
    localparam logic [1:0] BR_NE = 2'b01;
    localparam logic [1:0] BR_LT = 2'b10;
    localparam logic [1:0] BR_LE = 2'b11;

    // Branch condition from the ALU flags for a given branch type.
    function automatic logic branch_cond(input logic [1:0] br_type,
                                         input logic       zero,
                                         input logic       neg);
        logic cond;
        cond = 1'b0;
        unique case (br_type)
            BR_EQ:   cond = zero;
            BR_NE:   cond = !zero;
            BR_LT:   cond = neg;
            BR_LE:   cond = neg | zero;
            default: cond = 1'b0;
        endcase
        return cond;
    endfunction

endpackage

// File: rtl/next_pc_unit_if.sv
// Decode/datapath to next-PC unit signal bundle.
interface next_pc_unit_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
);
    logic            stall_i;
    logic            branch_i;
    logic [1:0]      branch_type_i;
    logic            zero_i;
    logic            neg_i;
    logic            jump_i;
    logic            jal_i;
    logic            jr_i;
    logic [XLEN-1:0] imm_i;
    logic [25:0]     jtarget_i;
    logic [XLEN-1:0] rs_data_i;

    logic [XLEN-1:0]  pc_o;
    logic [XLEN-1:0]  pc_plus4_o;
    logic [XLEN-1:0]  ras_top_o;
    logic             ras_empty_o;
    logic             ras_full_o;
    logic             mispredict_o;
    logic [CNT_W-1:0] mispred_cnt_o;

    // Decoder / datapath side.
    modport master (
        output stall_i, branch_i, branch_type_i, zero_i, neg_i, jump_i, jal_i, jr_i,
               imm_i, jtarget_i, rs_data_i,
        input  pc_o, pc_plus4_o, ras_top_o, ras_empty_o, ras_full_o, mispredict_o,
               mispred_cnt_o
    );

    // Next-PC unit side.
    modport slave (
        input  stall_i, branch_i, branch_type_i, zero_i, neg_i, jump_i, jal_i, jr_i,
               imm_i, jtarget_i, rs_data_i,
        output pc_o, pc_plus4_o, ras_top_o, ras_empty_o, ras_full_o, mispredict_o,
               mispred_cnt_o
    );

endinterface

// File: rtl/return_addr_stack.sv
// Circular return-address stack; pushing while full overwrites the oldest entry.
module return_addr_stack #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [XLEN-1:0] push_data_i,
    output logic [XLEN-1:0] top_o,
    output logic            empty_o,
    output logic            full_o
);
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned OCC_W = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0]  mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] top_idx;
    logic [OCC_W-1:0] occ_q;

    // Pop wins over push so an illegal jr+jal pair never pushes.
    logic do_push;
    assign do_push = push_i && !pop_i;

    assign empty_o = (occ_q == '0);
    assign full_o  = (occ_q == OCC_W'(RAS_DEPTH));
    assign top_idx = ptr_q - PTR_W'(1);
    assign top_o   = empty_o ? '0 : mem_q[top_idx];

    // Pointer and occupancy; the pointer wraps naturally since depth is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
            occ_q <= '0;
        end else if (pop_i) begin
            if (!empty_o) begin
                ptr_q <= ptr_q - PTR_W'(1);
                occ_q <= occ_q - OCC_W'(1);
            end
        end else if (do_push) begin
            ptr_q <= ptr_q + PTR_W'(1);
            if (!full_o) begin
                occ_q <= occ_q + OCC_W'(1);
            end
        end
    end

    // Entry storage; contents are don't-care after reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && do_push) begin
            mem_q[ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/next_pc_unit.sv
// Program counter with next-PC selection, jr prediction via RAS and mispredict counter.
module next_pc_unit
    import cpu_pkg::*;
#(
    parameter int unsigned     XLEN      = XLEN_DEFAULT,
    parameter int unsigned     RAS_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int unsigned     CNT_W     = 16
) (
    input logic           clk_i,
    input logic           rst_i,
    next_pc_unit_if.slave bus
);
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  pc_plus4;
    logic [XLEN-1:0]  br_target;
    logic [XLEN-1:0]  jump_target;
    logic [XLEN-1:0]  ras_top;
    logic             ras_empty;
    logic             ras_full;
    logic             br_taken;
    logic             mispredict;
    logic [CNT_W-1:0] cnt_q;

    assign pc_plus4    = pc_q + XLEN'(PC_STEP);
    assign br_target   = pc_plus4 + (bus.imm_i << 2);
    assign jump_target = {pc_plus4[XLEN-1:28], bus.jtarget_i, 2'b00};
    assign br_taken    = bus.branch_i && branch_cond(bus.branch_type_i, bus.zero_i, bus.neg_i);
    assign mispredict  = bus.jr_i && (ras_empty || (ras_top != bus.rs_data_i));

    // Next-PC priority: stall, jr, jump/jal, taken branch, sequential.
    always_comb begin
        pc_d = pc_plus4;
        if (bus.stall_i) begin
            pc_d = pc_q;
        end else if (bus.jr_i) begin
            pc_d = bus.rs_data_i;
        end else if (bus.jump_i || bus.jal_i) begin
            pc_d = jump_target;
        end else if (br_taken) begin
            pc_d = br_target;
        end
    end

    // PC register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Saturating jr mispredict counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (!bus.stall_i && mispredict && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    return_addr_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (bus.jal_i && !bus.stall_i),
        .pop_i       (bus.jr_i && !bus.stall_i),
        .push_data_i (pc_plus4),
        .top_o       (ras_top),
        .empty_o     (ras_empty),
        .full_o      (ras_full)
    );

    assign bus.pc_o          = pc_q;
    assign bus.pc_plus4_o    = pc_plus4;
    assign bus.ras_top_o     = ras_top;
    assign bus.ras_empty_o   = ras_empty;
    assign bus.ras_full_o    = ras_full;
    assign bus.mispredict_o  = mispredict;
    assign bus.mispred_cnt_o = cnt_q;

`ifndef SYNTHESIS
    // jr and jal together is an illegal decode.
    a_no_jr_jal: assert property (@(posedge clk_i) disable iff (rst_i)
                                  !(bus.jr_i && bus.jal_i));
`endif

endmodule
